pcie_tx_arbiter: RTL

PCIE_TX_ARBITER -- requirements
Module: pcie_tx_arbiter

---
 rtl/pcie_tx_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pcie_tx_arbiter.sv
// Transmit-side TLP arbiter: strict-priority completions, round-robin writes/reads,
// whole-TLP ownership of the AXI-stream link and a cap on non-posted reads in flight.
module pcie_tx_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        cpl_valid,
    input  logic [63:0] cpl_data,
    input  logic        cpl_last,
    input  logic        cpl_1dw,
    output logic        cpl_ready,

    input  logic        wr_valid,
    input  logic [63:0] wr_data,
    input  logic        wr_last,
    input  logic        wr_1dw,
    output logic        wr_ready,

    input  logic        rd_valid,
    input  logic [63:0] rd_data,
    input  logic        rd_last,
    input  logic        rd_1dw,
    output logic        rd_ready,

    input  logic        rd_done,

    output logic        tx_tvalid,
    output logic [63:0] tx_tdata,
    output logic        tx_tlast,
    output logic        tx_1dw,
    input  logic        tx_tready,

    output logic [1:0]  grant,
    output logic [3:0]  outstanding
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_CPL  = 2'd1;
    localparam logic [1:0] GNT_WR   = 2'd2;
    localparam logic [1:0] GNT_RD   = 2'd3;
    localparam logic [3:0] MAX_CNT  = 4'(MAX_OUTSTANDING);

    state_t state;
    logic   ptr_rd;
    logic   rd_eligible;
    logic   tx_done;
    logic   rd_inc;

    // grant is zero whenever the arbiter is idle, so the mux alone keeps every ready low there
    always_comb begin
        tx_tvalid = 1'b0;
        tx_tdata  = '0;
        tx_tlast  = 1'b0;
        tx_1dw    = 1'b0;
        cpl_ready = 1'b0;
        wr_ready  = 1'b0;
        rd_ready  = 1'b0;
        case (grant)
            GNT_CPL: begin
                tx_tvalid = cpl_valid;
                tx_tdata  = cpl_data;
                tx_tlast  = cpl_last;
                tx_1dw    = cpl_1dw;
                cpl_ready = tx_tready;
            end
            GNT_WR: begin
                tx_tvalid = wr_valid;
                tx_tdata  = wr_data;
                tx_tlast  = wr_last;
                tx_1dw    = wr_1dw;
                wr_ready  = tx_tready;
            end
            GNT_RD: begin
                tx_tvalid = rd_valid;
                tx_tdata  = rd_data;
                tx_tlast  = rd_last;
                tx_1dw    = rd_1dw;
                rd_ready  = tx_tready;
            end
            default: ;
        endcase
    end

    assign rd_eligible = rd_valid && (outstanding < MAX_CNT);
    assign tx_done     = tx_tvalid && tx_tready && tx_tlast;
    assign rd_inc      = (grant == GNT_RD) && rd_valid && tx_tready && rd_last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            grant  <= GNT_NONE;
            ptr_rd <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpl_valid) begin
                        grant <= GNT_CPL;
                        state <= BUSY;
                    end else if (wr_valid && (!rd_eligible || !ptr_rd)) begin
                        grant  <= GNT_WR;
                        ptr_rd <= 1'b1;
                        state  <= BUSY;
                    end else if (rd_eligible) begin
                        grant  <= GNT_RD;
                        ptr_rd <= 1'b0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (tx_done) begin
                        grant <= GNT_NONE;
                        state <= IDLE;
                    end
                end
                default: begin
                    grant <= GNT_NONE;
                    state <= IDLE;
                end
            endcase
        end
    end

    // A read leaving and its final completion arriving in the same cycle cancel out
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else if (rd_inc && !rd_done) begin
            outstanding <= outstanding + 4'd1;
        end else if (!rd_inc && rd_done && (outstanding != 4'd0)) begin
            outstanding <= outstanding - 4'd1;
        end
    end

endmodule
